key_scan_debounce: RTL and testbench



---
 rtl/dds_pkg.sv | 47 ++++
 rtl/key_sync.sv | 31 +++
 rtl/key_scan_debounce.sv | 149 ++++++++++++++
 tb/tb_key_scan_debounce.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
// Shared definitions for the DDS test-data generator front-end: key codes, FSM states, helpers.
// Latency: n/a (package).
// Backpressure: n/a (package).
`timescale 1ns/1ps
package dds_pkg;

  // Key codes seen by the DDS generator; bit i of the press vector maps to code i+1.
  localparam logic [3:0] KEY_NONE   = 4'd0;
  localparam logic [3:0] KEY_FRE_UP = 4'd1;
  localparam logic [3:0] KEY_FRE_DN = 4'd2;
  localparam logic [3:0] KEY_PHA_UP = 4'd3;
  localparam logic [3:0] KEY_PHA_DN = 4'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DEB_PRESS,
    ST_HELD,
    ST_REPEAT,
    ST_WAIT_REL
  } key_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  function automatic logic [3:0] onehot_to_code(input logic [3:0] v);
    logic [3:0] code;
    code = KEY_NONE;
    case (v)
      4'b0001: code = KEY_FRE_UP;
      4'b0010: code = KEY_FRE_DN;
      4'b0100: code = KEY_PHA_UP;
      4'b1000: code = KEY_PHA_DN;
      default: code = KEY_NONE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/key_sync.sv
// 2-flop synchroniser plus inversion of active-low buttons into a press vector (1 = pressed).
// Latency: 2 cycles from key change to o_kv change.
// Backpressure: none; free-running sampler.
// Ports: i_clk, i_rst_n (async, active-low), i_key_n [W] raw buttons, o_kv [W] synchronised press vector.
`timescale 1ns/1ps
module key_sync #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_key_n,
  output logic [W-1:0] o_kv
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  // Reset to all-released so keys held through reset must be debounced afresh.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= '1;
      r_sync <= '1;
    end else begin
      r_meta <= i_key_n;
      r_sync <= r_meta;
    end
  end

  assign o_kv = ~r_sync;

endmodule

// File: rtl/key_scan_debounce.sv
// Debounces four push-buttons and emits a one-cycle key code (1..4), with optional auto-repeat.
// Latency: clean press -> o_key_value on the edge DEB_CNT+3 cycles after the first low sample.
// Backpressure: none; the consumer must accept every single-cycle pulse.
// Ports: i_clk, i_rst_n (async, active-low), i_key_n [4] raw active-low buttons,
//        o_key_value [4] one-cycle code pulse (0 otherwise), o_key_held high in HELD/REPEAT.
`timescale 1ns/1ps
module key_scan_debounce
  import dds_pkg::*;
#(
  parameter int DEB_CNT    = 1_000_000,
  parameter int REPEAT_EN  = 1,
  parameter int REPEAT_DLY = 25_000_000,
  parameter int REPEAT_PER = 5_000_000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [3:0] i_key_n,
  output logic [3:0] o_key_value,
  output logic       o_key_held
);

  localparam int CW = $clog2(max3(DEB_CNT, REPEAT_DLY, REPEAT_PER)) + 1;

  localparam logic [CW-1:0] C_DEB     = CW'(DEB_CNT);
  localparam logic [CW-1:0] C_DEB_M1  = CW'(DEB_CNT - 1);
  localparam logic [CW-1:0] C_DLY     = CW'(REPEAT_DLY);
  localparam logic [CW-1:0] C_DLY_M1  = CW'(REPEAT_DLY - 1);
  localparam logic [CW-1:0] C_PER_M1  = CW'(REPEAT_PER - 1);
  localparam logic [CW-1:0] C_ONE     = CW'(1);

  logic [3:0]    w_kv;
  logic [3:0]    r_kv_d;
  logic [CW-1:0] r_stab_cnt;
  logic          r_stable;
  logic [CW-1:0] r_rep_cnt;
  logic [3:0]    r_code_oh;
  logic [3:0]    r_key_value;
  key_state_t    r_state;
  key_state_t    w_state_nxt;
  logic          w_pulse;
  logic [3:0]    w_pulse_oh;
  logic          w_latch;
  logic          w_rep_clr;
  logic          w_in_hold;

  key_sync #(.W(4)) u_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_key_n (i_key_n),
    .o_kv    (w_kv)
  );

  // Stability tracking. r_stable is a registered one-cycle strobe: it fires once the vector
  // now held in r_kv_d has been unchanged for DEB_CNT cycles, so FSM decisions use r_kv_d.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_kv_d     <= 4'd0;
      r_stab_cnt <= '0;
      r_stable   <= 1'b0;
    end else begin
      r_kv_d <= w_kv;
      if (w_kv != r_kv_d) begin
        r_stab_cnt <= '0;
      end else if (r_stab_cnt != C_DEB) begin
        r_stab_cnt <= r_stab_cnt + C_ONE;
      end
      r_stable <= (w_kv == r_kv_d) && (r_stab_cnt == C_DEB_M1);
    end
  end

  assign w_in_hold = (r_state == ST_HELD) || (r_state == ST_REPEAT);

  always_comb begin
    w_state_nxt = r_state;
    w_pulse     = 1'b0;
    w_pulse_oh  = r_code_oh;
    w_latch     = 1'b0;
    w_rep_clr   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_kv != 4'd0) w_state_nxt = ST_DEB_PRESS;
      end
      ST_DEB_PRESS: begin
        if (r_stable) begin
          if (r_kv_d == 4'd0) begin
            w_state_nxt = ST_IDLE;
          end else if (is_onehot(r_kv_d)) begin
            w_pulse     = 1'b1;
            w_pulse_oh  = r_kv_d;
            w_latch     = 1'b1;
            w_rep_clr   = 1'b1;
            w_state_nxt = ST_HELD;
          end else begin
            // Chord: never emit a code, wait for a full release.
            w_state_nxt = ST_WAIT_REL;
          end
        end else if (w_kv == 4'd0) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_HELD: begin
        if (w_kv != r_code_oh) begin
          w_state_nxt = ST_WAIT_REL;
        end else if ((REPEAT_EN != 0) && (r_rep_cnt == C_DLY_M1)) begin
          w_pulse     = 1'b1;
          w_rep_clr   = 1'b1;
          w_state_nxt = ST_REPEAT;
        end
      end
      ST_REPEAT: begin
        if (w_kv != r_code_oh) begin
          w_state_nxt = ST_WAIT_REL;
        end else if (r_rep_cnt == C_PER_M1) begin
          w_pulse   = 1'b1;
          w_rep_clr = 1'b1;
        end
      end
      ST_WAIT_REL: begin
        if (r_stable && (r_kv_d == 4'd0)) w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_key_value <= KEY_NONE;
      r_code_oh   <= 4'd0;
      r_rep_cnt   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_key_value <= w_pulse ? onehot_to_code(w_pulse_oh) : KEY_NONE;
      if (w_latch) r_code_oh <= r_kv_d;
      // Repeat timer only runs while a key is held; saturates so REPEAT_EN=0 never wraps.
      if (w_rep_clr || !w_in_hold) begin
        r_rep_cnt <= '0;
      end else if (r_rep_cnt != C_DLY) begin
        r_rep_cnt <= r_rep_cnt + C_ONE;
      end
    end
  end

  assign o_key_value = r_key_value;
  assign o_key_held  = w_in_hold;

endmodule

// File: tb/tb_key_scan_debounce.sv
`timescale 1ns/1ps
module tb_key_scan_debounce;
  import dds_pkg::*;

  localparam int DEB = 8;
  localparam int DLY = 20;
  localparam int PER = 5;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] key_n = 4'hF;
  logic [3:0] kv_rep, kv_one;
  logic       held_rep, held_one;

  int cyc    = 0;
  int errors = 0;
  int checks = 0;

  typedef struct {
    int         cyc;
    logic [3:0] code;
  } exp_t;

  exp_t q_rep[$];
  exp_t q_one[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  key_scan_debounce #(.DEB_CNT(DEB), .REPEAT_EN(1), .REPEAT_DLY(DLY), .REPEAT_PER(PER)) u_rep (
    .i_clk(clk), .i_rst_n(rst_n), .i_key_n(key_n), .o_key_value(kv_rep), .o_key_held(held_rep)
  );

  key_scan_debounce #(.DEB_CNT(DEB), .REPEAT_EN(0), .REPEAT_DLY(DLY), .REPEAT_PER(PER)) u_one (
    .i_clk(clk), .i_rst_n(rst_n), .i_key_n(key_n), .o_key_value(kv_one), .o_key_held(held_one)
  );

  task automatic chk(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (cyc %0d)", name, got, req, cyc);
    end
  endtask

  task automatic push(input int which, input int t, input logic [3:0] code);
    exp_t e;
    e.cyc  = t;
    e.code = code;
    if (which == 0) q_rep.push_back(e);
    else            q_one.push_back(e);
  endtask

  task automatic push_both(input int t, input logic [3:0] code);
    push(0, t, code);
    push(1, t, code);
  endtask

  task automatic check_pulse(input int which, input logic [3:0] code);
    exp_t e;
    int   sz;
    checks++;
    sz = (which == 0) ? q_rep.size() : q_one.size();
    if (sz == 0) begin
      errors++;
      $display("FAIL unexpected_pulse dut=%0d: got code %0d at cyc %0d, required no pulse", which, code, cyc);
    end else begin
      if (which == 0) e = q_rep.pop_front();
      else            e = q_one.pop_front();
      if ((e.cyc != cyc) || (e.code != code)) begin
        errors++;
        $display("FAIL pulse dut=%0d: got code %0d at cyc %0d, required code %0d at cyc %0d",
                 which, code, cyc, e.code, e.cyc);
      end
    end
  endtask

  // Monitor: every non-zero code must match the head of that DUT's expected queue.
  always @(negedge clk) begin
    if (kv_rep != KEY_NONE) check_pulse(0, kv_rep);
    if (kv_one != KEY_NONE) check_pulse(1, kv_one);
  end

  task automatic at(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int c;

    // Reset state
    at(2);
    chk("rst_value_rep", kv_rep, 0);
    chk("rst_value_one", kv_one, 0);
    chk("rst_held_rep", held_rep, 0);
    chk("rst_held_one", held_one, 0);
    chk("rst_state", int'(u_rep.r_state), int'(ST_IDLE));
    rst_n = 1'b1;
    at(cyc + 20);

    // 1: clean press of key 0, held 15 cycles
    c = cyc;
    key_n = 4'b1110;
    push_both(c + 12, KEY_FRE_UP);
    at(c + 14);
    chk("t1_held_rep", held_rep, 1);
    chk("t1_held_one", held_one, 1);
    at(c + 15);
    key_n = 4'hF;
    at(c + 21);
    chk("t1_rel_held_rep", held_rep, 0);
    chk("t1_rel_held_one", held_one, 0);
    at(c + 40);

    // 2: key 2 bouncing every 3 cycles, then stable low
    c = cyc;
    key_n = 4'b1011;
    at(c + 3);  key_n = 4'hF;
    at(c + 6);  key_n = 4'b1011;
    at(c + 9);  key_n = 4'hF;
    at(c + 11);
    chk("t2_bounce_held", held_rep, 0);
    at(c + 12); key_n = 4'b1011;
    push_both(c + 24, KEY_PHA_UP);
    at(c + 30); key_n = 4'hF;
    at(c + 55);

    // 3: key 1 held ~60 cycles: repeat on u_rep only
    c = cyc;
    key_n = 4'b1101;
    push_both(c + 12, KEY_FRE_DN);
    for (int k = 0; k < 6; k++) push(0, c + 32 + k * PER, KEY_FRE_DN);
    at(c + 40);
    chk("t3_held_rep", held_rep, 1);
    chk("t3_held_one", held_one, 1);
    at(c + 58); key_n = 4'hF;
    at(c + 85);
    chk("t3_rel_state", int'(u_rep.r_state), int'(ST_IDLE));

    // 4: key 0 held, key 3 added -> WAIT_REL; after release a fresh key 3 press works
    c = cyc;
    key_n = 4'b1110;
    push_both(c + 12, KEY_FRE_UP);
    at(c + 16); key_n = 4'b0110;
    at(c + 20);
    chk("t4_held_rep", held_rep, 0);
    chk("t4_held_one", held_one, 0);
    chk("t4_state_wait", int'(u_rep.r_state), int'(ST_WAIT_REL));
    at(c + 24); key_n = 4'hF;
    at(c + 39);
    chk("t4_state_idle", int'(u_rep.r_state), int'(ST_IDLE));
    at(c + 40); key_n = 4'b0111;
    push_both(c + 52, KEY_PHA_DN);
    at(c + 58); key_n = 4'hF;
    at(c + 80);

    // 5: keys 0 and 1 together -> no code, WAIT_REL then IDLE
    c = cyc;
    key_n = 4'b1100;
    at(c + 15);
    chk("t5_held_rep", held_rep, 0);
    chk("t5_held_one", held_one, 0);
    chk("t5_state_wait", int'(u_rep.r_state), int'(ST_WAIT_REL));
    at(c + 20); key_n = 4'hF;
    at(c + 35);
    chk("t5_state_idle", int'(u_rep.r_state), int'(ST_IDLE));
    at(c + 45);

    // 6: reset during REPEAT with key still held
    c = cyc;
    key_n = 4'b1101;
    push_both(c + 12, KEY_FRE_DN);
    push(0, c + 32, KEY_FRE_DN);
    at(c + 34);
    chk("t6_state_repeat", int'(u_rep.r_state), int'(ST_REPEAT));
    rst_n = 1'b0;
    #1;
    chk("t6_rst_value_rep", kv_rep, 0);
    chk("t6_rst_held_rep", held_rep, 0);
    chk("t6_rst_held_one", held_one, 0);
    at(c + 37);
    rst_n = 1'b1;
    push_both(c + 49, KEY_FRE_DN);
    at(c + 45);
    chk("t6_debounce_held", held_rep, 0);
    at(c + 55); key_n = 4'hF;
    at(c + 80);

    chk("missing_pulses_rep", q_rep.size(), 0);
    chk("missing_pulses_one", q_one.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
